// File: rtl/mbed_link_pkg.sv
// mbed_link_pkg: shared FSM states, constants and header helpers for the mbed frame packer
package mbed_link_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, SEND, GAP, FETCH, LATCH, DONE} state_t;
    localparam logic [15:0] FILLER_WORD = 16'hFFFF;
    localparam int GAP_CYCLES = 2;
    function automatic logic [15:0] header_word(input logic [7:0] tag, input logic [7:0] seq);
        return {tag, seq};
    endfunction
    function automatic logic [7:0] header_seq(input logic [15:0] word);
        return word[7:0];
    endfunction
endpackage

// File: rtl/sync_edge.sv
// sync_edge: optional 2-flop synchroniser followed by a rising-edge detector
module sync_edge #(
    parameter bit BYPASS = 1'b0
) (
    input  logic SYS_CLK,
    input  logic reset,
    input  logic d,
    output logic rise
);
    logic [1:0] sync;
    logic       prev;
    logic       lvl;
    assign lvl  = BYPASS ? d : sync[1];
    assign rise = lvl & ~prev;
    always_ff @(posedge SYS_CLK) begin
        if (reset) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[0], d};
            prev <= lvl;
        end
    end
endmodule

// File: rtl/mbed_frame_packer.sv
// mbed_frame_packer: frames FIFO samples as header/samples/checksum words paced by the SPI ENA/FIN handshake
module mbed_frame_packer #(
    parameter int          SAMPLES_PER_FRAME = 32,
    parameter int          UNDERRUN_TIMEOUT  = 256,
    parameter logic [7:0]  HEADER_TAG        = 8'hA5
) (
    input  logic        SYS_CLK,
    input  logic        reset,
    input  logic        mbed_rdy,
    input  logic        fifo_empty,
    output logic        fifo_rd,
    input  logic [15:0] fifo_dout,
    output logic        spi_ena,
    output logic [15:0] spi_data,
    input  logic        spi_fin,
    output logic        frame_active,
    output logic [7:0]  frame_seq,
    output logic [7:0]  underrun_cnt
);
    import mbed_link_pkg::*;
    localparam int         WW   = $clog2(UNDERRUN_TIMEOUT + 1);
    localparam logic [7:0] SPF8 = 8'(SAMPLES_PER_FRAME);
    state_t          state, state_nx;
    logic            rdy_rise, fin_rise;
    logic [7:0]      smp_cnt;
    logic [1:0]      gap_cnt;
    logic [WW-1:0]   wait_cnt;
    logic            cs_sent;
    logic [15:0]     word, csum;
    logic            ld_hdr, ld_smp, ld_fill, ld_cs;
    logic            gap_last, wait_last;
    sync_edge #(.BYPASS(1'b0)) u_rdy (
        .SYS_CLK (SYS_CLK),
        .reset   (reset),
        .d       (mbed_rdy),
        .rise    (rdy_rise)
    );
    sync_edge #(.BYPASS(1'b1)) u_fin (
        .SYS_CLK (SYS_CLK),
        .reset   (reset),
        .d       (spi_fin),
        .rise    (fin_rise)
    );
    assign gap_last     = gap_cnt == 2'(GAP_CYCLES - 1);
    assign wait_last    = wait_cnt == WW'(UNDERRUN_TIMEOUT - 1);
    assign spi_ena      = (state == LOAD) || (state == SEND);
    assign spi_data     = word;
    assign fifo_rd      = (state == FETCH) && !fifo_empty;
    assign frame_active = (state != IDLE) && (state != DONE);
    always_ff @(posedge SYS_CLK) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        ld_hdr   = 1'b0;
        ld_smp   = 1'b0;
        ld_fill  = 1'b0;
        ld_cs    = 1'b0;
        case (state)
            IDLE:  if (rdy_rise) begin
                       ld_hdr   = 1'b1;
                       state_nx = LOAD;
                   end
            LOAD:  state_nx = SEND;
            SEND:  state_nx = fin_rise ? GAP : SEND;
            GAP:   if (gap_last) begin
                       if (cs_sent)              state_nx = DONE;
                       else if (smp_cnt < SPF8)  state_nx = FETCH;
                       else begin
                           ld_cs    = 1'b1;
                           state_nx = LOAD;
                       end
                   end
            // a non-empty FIFO always wins, even on the last wait cycle
            FETCH: if (!fifo_empty) state_nx = LATCH;
                   else if (wait_last) begin
                       ld_fill  = 1'b1;
                       state_nx = LOAD;
                   end
            LATCH: begin
                       ld_smp   = 1'b1;
                       state_nx = LOAD;
                   end
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge SYS_CLK) begin
        if (reset) begin
            smp_cnt      <= '0;
            gap_cnt      <= '0;
            wait_cnt     <= '0;
            cs_sent      <= 1'b0;
            word         <= '0;
            csum         <= '0;
            frame_seq    <= '0;
            underrun_cnt <= '0;
        end else begin
            gap_cnt  <= (state == GAP) ? gap_cnt + 2'd1 : 2'd0;
            wait_cnt <= (state == FETCH && fifo_empty && !wait_last) ? wait_cnt + WW'(1) : '0;
            if (ld_hdr) begin
                word    <= header_word(HEADER_TAG, frame_seq);
                csum    <= header_word(HEADER_TAG, frame_seq);
                smp_cnt <= '0;
                cs_sent <= 1'b0;
            end
            if (ld_smp) begin
                word    <= fifo_dout;
                csum    <= csum + fifo_dout;
                smp_cnt <= smp_cnt + 8'd1;
            end
            if (ld_fill) begin
                word         <= FILLER_WORD;
                csum         <= csum + FILLER_WORD;
                smp_cnt      <= smp_cnt + 8'd1;
                underrun_cnt <= (underrun_cnt == 8'hFF) ? underrun_cnt : underrun_cnt + 8'd1;
            end
            if (ld_cs) begin
                word    <= csum;
                cs_sent <= 1'b1;
            end
            if (state == DONE) frame_seq <= frame_seq + 8'd1;
        end
    end
endmodule

// File: tb/tb_mbed_frame_packer.sv
// tb_mbed_frame_packer: table-driven and randomized frame checks against a word-list reference model
module tb_mbed_frame_packer;
    localparam int SPF = 32;
    localparam int TMO = 16;
    localparam int WPF = SPF + 2;

    typedef struct {
        int          n;
        logic [15:0] base;
        int          lat;
        logic [15:0] hdr;
        logic [15:0] cs;
        logic [7:0]  und;
        logic [7:0]  seq;
    } vec_t;

    logic        SYS_CLK = 1'b0;
    logic        reset = 1'b1;
    logic        mbed_rdy = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [15:0] fifo_dout = 16'h0;
    logic        spi_fin = 1'b0;
    logic        fifo_rd, spi_ena, frame_active;
    logic [15:0] spi_data;
    logic [7:0]  frame_seq, underrun_cnt;

    int          errors = 0;
    int          checks = 0;
    int          rd_cnt = 0;
    int          fin_lat = 1;
    bit          fin_manual = 1'b0;
    logic [15:0] fifo_q[$];
    logic [15:0] got[$];
    logic [15:0] exp_q[$];
    logic [15:0] data_q[$];
    logic [7:0]  seq_m = 8'd0;
    int          und_m = 0;
    vec_t        tbl[4];

    mbed_frame_packer #(
        .SAMPLES_PER_FRAME (SPF),
        .UNDERRUN_TIMEOUT  (TMO),
        .HEADER_TAG        (8'hA5)
    ) dut (
        .SYS_CLK      (SYS_CLK),
        .reset        (reset),
        .mbed_rdy     (mbed_rdy),
        .fifo_empty   (fifo_empty),
        .fifo_rd      (fifo_rd),
        .fifo_dout    (fifo_dout),
        .spi_ena      (spi_ena),
        .spi_data     (spi_data),
        .spi_fin      (spi_fin),
        .frame_active (frame_active),
        .frame_seq    (frame_seq),
        .underrun_cnt (underrun_cnt)
    );

    always #10 SYS_CLK = ~SYS_CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // FIFO and SPI-slave models: reads sampled mid-cycle, responses driven just after the edge
    initial begin : bfm
        bit          rd_pend, in_word;
        int          lat;
        logic [15:0] cur;
        in_word = 1'b0;
        lat = 0;
        cur = 16'h0;
        forever begin
            @(negedge SYS_CLK);
            rd_pend = fifo_rd;
            if (fifo_rd) begin
                rd_cnt++;
                chk("fifo_rd_while_empty", fifo_empty, 1'b0);
            end
            @(posedge SYS_CLK);
            #1;
            if (rd_pend && fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
            fifo_empty = (fifo_q.size() == 0);
            if (!fin_manual) begin
                if (!spi_ena) begin
                    spi_fin = 1'b0;
                    in_word = 1'b0;
                end else if (!in_word) begin
                    in_word = 1'b1;
                    cur = spi_data;
                    lat = 0;
                end else if (!spi_fin) begin
                    lat++;
                    if (lat >= fin_lat) begin
                        chk("spi_data_stable", spi_data, cur);
                        got.push_back(cur);
                        spi_fin = 1'b1;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Reference: header, SPF words (FIFO data then fillers), 16-bit wrapped sum of all of them
    task automatic model();
        logic [15:0] s, w;
        exp_q = {};
        s = {8'hA5, seq_m};
        exp_q.push_back(s);
        for (int i = 0; i < SPF; i++) begin
            if (i < data_q.size()) w = data_q[i];
            else begin
                w = 16'hFFFF;
                und_m = (und_m < 255) ? und_m + 1 : 255;
            end
            s = s + w;
            exp_q.push_back(w);
        end
        exp_q.push_back(s);
        seq_m = seq_m + 8'd1;
    endtask

    task automatic fill_fifo(input int n, input logic [15:0] base);
        data_q = {};
        for (int i = 0; i < n; i++) begin
            data_q.push_back(base + 16'(i));
            fifo_q.push_back(base + 16'(i));
        end
    endtask

    task automatic fill_rand(input int n);
        logic [15:0] w;
        data_q = {};
        for (int i = 0; i < n; i++) begin
            w = 16'($urandom);
            data_q.push_back(w);
            fifo_q.push_back(w);
        end
    endtask

    task automatic request();
        @(negedge SYS_CLK) mbed_rdy = 1'b1;
        repeat (2) @(negedge SYS_CLK);
        mbed_rdy = 1'b0;
    endtask

    task automatic wait_frame(input int n, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 8000; c++) begin
            @(negedge SYS_CLK);
            if (got.size() >= n && !frame_active) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge SYS_CLK);
    endtask

    task automatic run(input string name, input int lat, output bit ok);
        got = {};
        fin_lat = lat;
        request();
        wait_frame(WPF, ok);
        chk({name, "_frame_done"}, ok, 1'b1);
    endtask

    task automatic cmp_frame(input string name, input int skip);
        int bad;
        bad = -1;
        chk({name, "_word_count"}, got.size(), WPF - skip);
        for (int i = 0; i < got.size() && i + skip < exp_q.size(); i++)
            if (bad < 0 && got[i] !== exp_q[i + skip]) bad = i;
        chk({name, "_first_bad_word_index"}, bad, -1);
        if (bad >= 0) $display("  %s word %0d: got %h, expected %h", name, bad, got[bad], exp_q[bad + skip]);
    endtask

    initial begin : main
        bit          ok;
        int          r0, n;
        logic [15:0] prev_hdr;
        tbl[0] = '{32, 16'h0001, 1, 16'hA500, 16'hA710, 8'd0,  8'd1};
        tbl[1] = '{30, 16'h0001, 2, 16'hA501, 16'hA6D0, 8'd2,  8'd2};
        tbl[2] = '{32, 16'hFFF0, 3, 16'hA502, 16'hA4F2, 8'd2,  8'd3};
        tbl[3] = '{0,  16'h0000, 1, 16'hA503, 16'hA4E3, 8'd34, 8'd4};
        repeat (3) @(negedge SYS_CLK);
        chk("rst_spi_ena", spi_ena, 1'b0);
        chk("rst_fifo_rd", fifo_rd, 1'b0);
        chk("rst_spi_data", spi_data, 16'h0);
        chk("rst_frame_active", frame_active, 1'b0);
        chk("rst_frame_seq", frame_seq, 8'd0);
        chk("rst_underrun_cnt", underrun_cnt, 8'd0);
        reset = 1'b0;
        repeat (3) @(negedge SYS_CLK);

        for (int t = 0; t < 4; t++) begin
            r0 = rd_cnt;
            fill_fifo(tbl[t].n, tbl[t].base);
            model();
            run($sformatf("tbl%0d", t), tbl[t].lat, ok);
            chk($sformatf("tbl%0d_header", t), got.size() > 0 ? got[0] : 16'h0, tbl[t].hdr);
            chk($sformatf("tbl%0d_checksum", t), got.size() == WPF ? got[WPF-1] : 16'h0, tbl[t].cs);
            cmp_frame($sformatf("tbl%0d", t), 0);
            chk($sformatf("tbl%0d_underrun_cnt", t), underrun_cnt, tbl[t].und);
            chk($sformatf("tbl%0d_frame_seq", t), frame_seq, tbl[t].seq);
            chk($sformatf("tbl%0d_fifo_rd_pulses", t), rd_cnt - r0, tbl[t].n < SPF ? tbl[t].n : SPF);
            chk($sformatf("tbl%0d_frame_active", t), frame_active, 1'b0);
        end

        for (int r = 0; r < 5; r++) begin
            n = $urandom_range(28, SPF);
            fill_rand(n);
            model();
            run($sformatf("rand%0d", r), $urandom_range(1, 4), ok);
            cmp_frame($sformatf("rand%0d", r), 0);
            chk($sformatf("rand%0d_underrun_cnt", r), underrun_cnt, und_m);
            chk($sformatf("rand%0d_frame_seq", r), frame_seq, seq_m);
        end

        fill_rand(SPF);
        fifo_q = {};
        for (int i = 0; i < 5; i++) fifo_q.push_back(data_q[i]);
        model();
        got = {};
        fin_lat = 1;
        r0 = rd_cnt;
        request();
        for (int c = 0; c < 2000 && rd_cnt < r0 + 5; c++) @(negedge SYS_CLK);
        repeat (10) @(negedge SYS_CLK);
        for (int i = 5; i < SPF; i++) fifo_q.push_back(data_q[i]);
        wait_frame(WPF, ok);
        chk("late_fill_frame_done", ok, 1'b1);
        cmp_frame("late_fill", 0);
        chk("late_fill_underrun_cnt", underrun_cnt, und_m);

        fill_rand(SPF);
        model();
        got = {};
        fin_lat = 2;
        request();
        fork
            begin
                for (int c = 0; c < 5000 && got.size() < 30; c++) begin
                    @(negedge SYS_CLK);
                    mbed_rdy = ~mbed_rdy;
                end
                mbed_rdy = 1'b0;
            end
            wait_frame(WPF, ok);
        join
        repeat (60) @(negedge SYS_CLK);
        chk("toggle_frame_done", ok, 1'b1);
        cmp_frame("toggle", 0);
        chk("toggle_frame_seq", frame_seq, seq_m);
        chk("toggle_no_new_frame", frame_active, 1'b0);

        fill_fifo(SPF, 16'h0100);
        model();
        got = {};
        fin_manual = 1'b1;
        spi_fin = 1'b1;
        request();
        for (int c = 0; c < 50 && !spi_ena; c++) @(negedge SYS_CLK);
        chk("fin_high_load_seen", spi_ena, 1'b1);
        repeat (8) @(negedge SYS_CLK);
        chk("fin_high_no_advance", spi_ena, 1'b1);
        chk("fin_high_header", spi_data, exp_q[0]);
        spi_fin = 1'b0;
        repeat (3) @(negedge SYS_CLK);
        chk("fin_low_still_waiting", spi_ena, 1'b1);
        spi_fin = 1'b1;
        @(posedge SYS_CLK);
        #2;
        chk("fin_fresh_edge_advances", spi_ena, 1'b0);
        fin_manual = 1'b0;
        wait_frame(WPF - 1, ok);
        chk("fin_frame_done", ok, 1'b1);
        cmp_frame("fin_hold", 1);

        fill_fifo(SPF, 16'h0200);
        got = {};
        fin_lat = 2;
        request();
        for (int c = 0; c < 4000 && !(got.size() == 10 && spi_ena); c++) @(negedge SYS_CLK);
        chk("rst_mid_reached_word10", got.size(), 10);
        reset = 1'b1;
        @(posedge SYS_CLK);
        #2;
        chk("rst_mid_spi_ena", spi_ena, 1'b0);
        chk("rst_mid_fifo_rd", fifo_rd, 1'b0);
        chk("rst_mid_frame_active", frame_active, 1'b0);
        chk("rst_mid_frame_seq", frame_seq, 8'd0);
        chk("rst_mid_underrun_cnt", underrun_cnt, 8'd0);
        @(negedge SYS_CLK);
        reset = 1'b0;
        fifo_q = {};
        seq_m = 8'd0;
        und_m = 0;
        repeat (4) @(negedge SYS_CLK);

        fill_fifo(SPF, 16'h0001);
        model();
        got = {};
        fin_lat = 1;
        @(negedge SYS_CLK) mbed_rdy = 1'b1;
        @(posedge SYS_CLK);
        @(posedge SYS_CLK);
        #2;
        chk("latency_edge_n1_ena", spi_ena, 1'b0);
        @(posedge SYS_CLK);
        #2;
        chk("latency_edge_n2_ena", spi_ena, 1'b1);
        chk("latency_edge_n2_header", spi_data, 16'hA500);
        @(negedge SYS_CLK) mbed_rdy = 1'b0;
        wait_frame(WPF, ok);
        chk("post_reset_frame_done", ok, 1'b1);
        cmp_frame("post_reset", 0);
        chk("post_reset_checksum", got.size() == WPF ? got[WPF-1] : 16'h0, 16'hA710);

        prev_hdr = 16'h0;
        for (int f = 0; f < 256; f++) begin
            fill_fifo(SPF, 16'(f * 7));
            model();
            run("wrap", 1, ok);
            if (!ok) break;
            cmp_frame("wrap", 0);
            if (prev_hdr == 16'hA5FF) chk("wrap_header_after_A5FF", got[0], 16'hA500);
            prev_hdr = got[0];
        end
        chk("wrap_final_frame_seq", frame_seq, seq_m);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
